// File: rtl/uart_rom_loader.sv
// UART 8N1 receiver feeding a ROM stream loader: 0xA5, 16-bit length, then 16-bit words, high byte first.
// Optional trailing checksum byte when UART_LOADER_CHECKSUM_EN is defined.
module uart_rom_loader #(
    parameter int CLKS_PER_BIT  = 217,
    parameter int ADDRESS_WIDTH = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        uart_rx,
    output logic        rom_loader_reset,
    output logic        rom_loader_load,
    output logic [15:0] rom_loader_data,
    input  logic        rom_loader_ack,
    input  logic        rom_loader_load_received,
    output logic        hack_external_reset,
    output logic        busy,
    output logic        error,
    output logic [5:0]  state_dbg
);
    localparam int          CW      = ADDRESS_WIDTH + 1;
    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);
    localparam logic [16:0] MAX_LEN = 17'(2 ** ADDRESS_WIDTH);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [3:0] {
        IDLE, LEN_H, LEN_L, WAIT_RECV, DATA_H, DATA_L, PRESENT, ACK_LOW,
`ifdef UART_LOADER_CHECKSUM_EN
        CHECK,
`endif
        DONE, ERROR
    } state_t;

    rx_state_t   rx_state, rx_state_n;
    logic        rx_meta, rx_sync, rx_prev;
    logic [15:0] bit_cnt, bit_cnt_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [7:0]  rx_shift, rx_shift_n;
    logic        rx_valid, rx_valid_n, rx_ferr, rx_ferr_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_meta  <= uart_rx;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_state <= rx_state_n;
            bit_cnt  <= bit_cnt_n;
            bit_idx  <= bit_idx_n;
            rx_shift <= rx_shift_n;
            rx_valid <= rx_valid_n;
            rx_ferr  <= rx_ferr_n;
        end
    end

    // Start bit is confirmed half a bit after the falling edge; every later sample lands mid-bit.
    always_comb begin
        rx_state_n = rx_state;
        bit_cnt_n  = bit_cnt + 16'd1;
        bit_idx_n  = bit_idx;
        rx_shift_n = rx_shift;
        rx_valid_n = 1'b0;
        rx_ferr_n  = rx_ferr;
        case (rx_state)
            RX_IDLE: begin
                bit_cnt_n = '0;
                if (rx_prev && !rx_sync) rx_state_n = RX_START;
            end
            RX_START: if (bit_cnt == HALF_M1) begin
                bit_cnt_n  = '0;
                bit_idx_n  = '0;
                rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (bit_cnt == FULL_M1) begin
                bit_cnt_n  = '0;
                rx_shift_n = {rx_sync, rx_shift[7:1]};
                bit_idx_n  = bit_idx + 3'd1;
                if (bit_idx == 3'd7) rx_state_n = RX_STOP;
            end
            RX_STOP: if (bit_cnt == FULL_M1) begin
                bit_cnt_n  = '0;
                rx_valid_n = 1'b1;
                rx_ferr_n  = !rx_sync;
                rx_state_n = RX_IDLE;
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    state_t        state, state_n;
    logic [7:0]    len_h, len_h_n, data_h, data_h_n, byte_buf, byte_buf_n;
    logic          buf_valid, buf_valid_n, done_cnt, done_cnt_n;
    logic [CW-1:0] word_cnt, word_cnt_n;
    logic          load_n, hack_n, pulse_n, err_n;
    logic [15:0]   data_n;
    logic [7:0]    sum, sum_n;
    logic          good_byte, have_byte, consume, go_err;
    logic [7:0]    cur_byte;

    assign good_byte = rx_valid && !rx_ferr;
    assign have_byte = buf_valid || good_byte;
    assign cur_byte  = buf_valid ? byte_buf : rx_shift;
    assign busy      = (state != IDLE);
    assign state_dbg = {rx_state, state};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state               <= IDLE;
            len_h               <= '0;
            data_h              <= '0;
            byte_buf            <= '0;
            buf_valid           <= 1'b0;
            done_cnt            <= 1'b0;
            word_cnt            <= '0;
            sum                 <= '0;
            rom_loader_load     <= 1'b0;
            rom_loader_reset    <= 1'b0;
            rom_loader_data     <= '0;
            hack_external_reset <= 1'b0;
            error               <= 1'b0;
        end else begin
            state               <= state_n;
            len_h               <= len_h_n;
            data_h              <= data_h_n;
            byte_buf            <= byte_buf_n;
            buf_valid           <= buf_valid_n;
            done_cnt            <= done_cnt_n;
            word_cnt            <= word_cnt_n;
            sum                 <= sum_n;
            rom_loader_load     <= load_n;
            rom_loader_reset    <= pulse_n;
            rom_loader_data     <= data_n;
            hack_external_reset <= hack_n;
            error               <= err_n;
        end
    end

    // Handshake: rom_loader_data is held from entry to PRESENT until ack rises; the next word is
    // only fetched after ack has returned low. Bytes arriving meanwhile wait in a one-byte buffer.
    always_comb begin
        state_n     = state;
        len_h_n     = len_h;
        data_h_n    = data_h;
        byte_buf_n  = byte_buf;
        buf_valid_n = buf_valid;
        done_cnt_n  = 1'b0;
        word_cnt_n  = word_cnt;
        sum_n       = sum;
        load_n      = rom_loader_load;
        hack_n      = hack_external_reset;
        pulse_n     = 1'b0;
        err_n       = error;
        data_n      = rom_loader_data;
        consume     = 1'b0;
        go_err      = 1'b0;
        if ((state == PRESENT || state == ACK_LOW) && good_byte) begin
            if (buf_valid) begin
                go_err = 1'b1;
            end else begin
                buf_valid_n = 1'b1;
                byte_buf_n  = rx_shift;
            end
        end
        case (state)
            IDLE: begin
                buf_valid_n = 1'b0;
                if (good_byte && rx_shift == 8'hA5) begin
                    state_n = LEN_H;
                    err_n   = 1'b0;
                    hack_n  = 1'b1;
                    sum_n   = '0;
                end
            end
            LEN_H: if (have_byte) begin
                consume = 1'b1;
                len_h_n = cur_byte;
                state_n = LEN_L;
            end
            LEN_L: if (have_byte) begin
                consume = 1'b1;
                if ({len_h, cur_byte} == 16'd0 || {1'b0, len_h, cur_byte} > MAX_LEN) begin
                    go_err = 1'b1;
                end else begin
                    word_cnt_n = CW'({len_h, cur_byte});
                    pulse_n    = 1'b1;
                    load_n     = 1'b1;
                    state_n    = WAIT_RECV;
                end
            end
            WAIT_RECV: begin
                if (rx_valid) go_err = 1'b1;
                else if (rom_loader_load_received) state_n = DATA_H;
            end
            DATA_H: if (have_byte) begin
                consume  = 1'b1;
                data_h_n = cur_byte;
                state_n  = DATA_L;
            end
            DATA_L: if (have_byte) begin
                consume = 1'b1;
                data_n  = {data_h, cur_byte};
                state_n = PRESENT;
            end
            PRESENT: if (rom_loader_ack) begin
                state_n    = ACK_LOW;
                word_cnt_n = word_cnt - CW'(1);
            end
            ACK_LOW: if (!rom_loader_ack) begin
                if (word_cnt != '0) begin
                    state_n = DATA_H;
                end else begin
`ifdef UART_LOADER_CHECKSUM_EN
                    state_n = CHECK;
`else
                    state_n = DONE;
                    load_n  = 1'b0;
`endif
                end
            end
`ifdef UART_LOADER_CHECKSUM_EN
            CHECK: if (have_byte) begin
                consume = 1'b1;
                if (8'(sum + cur_byte) == 8'h00) begin
                    state_n = DONE;
                    load_n  = 1'b0;
                end else begin
                    go_err = 1'b1;
                end
            end
`endif
            DONE: begin
                done_cnt_n = 1'b1;
                if (done_cnt) begin
                    hack_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            ERROR: begin
                buf_valid_n = 1'b0;
                state_n     = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (rx_valid && rx_ferr && state != IDLE) go_err = 1'b1;
        if (consume) begin
            buf_valid_n = buf_valid && good_byte;
            byte_buf_n  = rx_shift;
            sum_n       = sum + cur_byte;
        end
        if (go_err) begin
            state_n     = ERROR;
            load_n      = 1'b0;
            hack_n      = 1'b0;
            err_n       = 1'b1;
            buf_valid_n = 1'b0;
        end
    end
endmodule
